daa_exec: RTL and testbench

- Sequencing/write-back stage for the Z80 DAA instruction.
- Latches accumulator and flags, presents them to the combinational DAA correction decoder, and samples the decoder's correction word and carry.
- Adds the correction to A, builds the full Z80 flag byte, and hands the result back to the register file with a single-cycle done pulse.
- Sits between the instruction sequencer (start/busy) and the A/F write-back path.

---
 rtl/daa_exec.sv | 133 +++++++++++++
 tb/tb_daa_exec.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/daa_exec.sv
// Write-back stage for the Z80 DAA instruction: latches A/F, samples the
// external correction decoder, adds the correction and builds the new flag byte.
module daa_exec #(
  parameter bit XY_FROM_RESULT = 1'b1,
  parameter int CORR_W         = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        a_in,
  input  logic [7:0]        f_in,
  output logic [7:0]        dec_a,
  output logic [7:0]        dec_f,
  input  logic [CORR_W-1:0] corr_in,
  input  logic              corr_c_in,
  output logic              busy,
  output logic              done,
  output logic [7:0]        a_out,
  output logic [7:0]        f_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC  = 2'd1,
    ADD  = 2'd2,
    FLAG = 2'd3
  } state_t;

  state_t      state_r;
  logic [7:0]  a_r;
  logic [7:0]  f_r;
  logic [7:0]  corr_r;
  logic        c_r;
  logic [7:0]  sum_r;
  logic        busy_r;
  logic        done_r;
  logic [7:0]  a_out_r;
  logic [7:0]  f_out_r;
  logic [7:0]  flags_s;
  logic        half_s;

  // Even parity: 1 when the byte holds an even number of ones
  function automatic logic even_parity(input logic [7:0] v);
    even_parity = ~(^v);
  endfunction

  // Only the low byte of the correction word carries information
  generate
    if (CORR_W > 8) begin : g_corr_hi
      logic unused_corr_hi_s;
      assign unused_corr_hi_s = ^corr_in[CORR_W-1:8];
    end
  endgenerate

  // Half-carry follows the Z80 rule, evaluated on the original accumulator
  always_comb begin
    half_s = 1'b0;
    if (f_r[1]) begin
      half_s = f_r[4] & (a_r[3:0] < 4'd6);
    end else begin
      half_s = (a_r[3:0] > 4'd9);
    end
  end

  // Assemble the new flag byte from the registered sum
  always_comb begin
    flags_s    = 8'h00;
    flags_s[7] = sum_r[7];
    flags_s[6] = (sum_r == 8'h00);
    flags_s[5] = XY_FROM_RESULT ? sum_r[5] : 1'b0;
    flags_s[4] = half_s;
    flags_s[3] = XY_FROM_RESULT ? sum_r[3] : 1'b0;
    flags_s[2] = even_parity(sum_r);
    flags_s[1] = f_r[1];
    flags_s[0] = c_r;
  end

  // Sequencer: IDLE -> DEC -> ADD -> FLAG -> IDLE, all outputs registered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      a_r     <= 8'h00;
      f_r     <= 8'h00;
      corr_r  <= 8'h00;
      c_r     <= 1'b0;
      sum_r   <= 8'h00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      a_out_r <= 8'h00;
      f_out_r <= 8'h00;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a_in;
            f_r     <= f_in;
            busy_r  <= 1'b1;
            state_r <= DEC;
          end
        end
        DEC: begin
          corr_r  <= corr_in[7:0];
          c_r     <= corr_c_in;
          state_r <= ADD;
        end
        ADD: begin
          sum_r   <= a_r + corr_r;
          state_r <= FLAG;
        end
        FLAG: begin
          a_out_r <= sum_r;
          f_out_r <= flags_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign dec_a = a_r;
  assign dec_f = f_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign a_out = a_out_r;
  assign f_out = f_out_r;

endmodule

// File: tb/tb_daa_exec.sv
// Directed and sweep bench for daa_exec; a second instance checks XY_FROM_RESULT=0.
module tb_daa_exec;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  a_in, f_in;
  logic [15:0] corr_in;
  logic        corr_c_in;
  logic [7:0]  dec_a, dec_f, a_out, f_out;
  logic        busy, done;
  logic [7:0]  dec_a0, dec_f0, a_out0, f_out0;
  logic        busy0, done0;

  int vectors = 0;
  int miscompares = 0;

  daa_exec #(.XY_FROM_RESULT(1'b1), .CORR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a_in(a_in), .f_in(f_in),
    .dec_a(dec_a), .dec_f(dec_f), .corr_in(corr_in), .corr_c_in(corr_c_in),
    .busy(busy), .done(done), .a_out(a_out), .f_out(f_out)
  );

  daa_exec #(.XY_FROM_RESULT(1'b0), .CORR_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .a_in(a_in), .f_in(f_in),
    .dec_a(dec_a0), .dec_f(dec_f0), .corr_in(corr_in), .corr_c_in(corr_c_in),
    .busy(busy0), .done(done0), .a_out(a_out0), .f_out(f_out0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_inputs();
    logic [31:0] r;
    r = $urandom;
    corr_in   = r[15:0];
    corr_c_in = r[16];
  endtask

  // Reference correction decoder (what the external combinational block provides)
  task automatic dec_model(input logic [7:0] a, input logic [7:0] f,
                           output logic [15:0] corr, output logic cy);
    logic [7:0] d;
    d  = 8'h00;
    cy = f[0];
    if (f[4] || (a[3:0] > 4'd9)) d = d | 8'h06;
    if (f[0] || (a > 8'h99)) begin
      d  = d | 8'h60;
      cy = 1'b1;
    end
    corr = {8'h00, (f[1] ? (8'h00 - d) : d)};
  endtask

  // Z80 DAA reference: result and full flag byte
  task automatic daa_ref(input logic [7:0] a, input logic [7:0] f,
                         output logic [7:0] ra, output logic [7:0] rf);
    logic n, h, c, hn, cn;
    int   ones;
    n  = f[1]; h = f[4]; c = f[0];
    ra = a;
    cn = c;
    if (c || a > 8'h99) begin
      ra = n ? ra - 8'h60 : ra + 8'h60;
      cn = 1'b1;
    end
    if (h || a[3:0] > 4'd9) ra = n ? ra - 8'h06 : ra + 8'h06;
    hn = n ? (h && a[3:0] < 4'd6) : (a[3:0] > 4'd9);
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(ra[i]);
    rf = {ra[7], (ra == 8'h00), ra[5], hn, ra[3], ((ones % 2) == 0), n, cn};
  endtask

  // Full transaction with per-cycle checks; corr is valid only across the DEC edge
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] f,
                        input logic [15:0] corr, input logic cy,
                        input logic [7:0] ea, input logic [7:0] ef);
    logic [31:0] r;
    start = 1'b1; a_in = a; f_in = f;
    junk_inputs();
    tick();
    check({tag, ".busy"}, {15'd0, busy}, 16'd1);
    check({tag, ".dec"}, {dec_a, dec_f}, {a, f});
    r = $urandom;
    start = 1'b0; a_in = r[7:0]; f_in = r[15:8];
    corr_in = {r[23:16], corr[7:0]}; corr_c_in = cy;
    tick();
    check({tag, ".done_early"}, {15'd0, done}, 16'd0);
    junk_inputs();
    tick();
    tick();
    check({tag, ".done"}, {14'd0, done, busy}, 16'b10);
    check({tag, ".af"}, {a_out, f_out}, {ea, ef});
    check({tag, ".af_xy0"}, {a_out0, f_out0}, {ea, ef & 8'hD7});
    tick();
    check({tag, ".done_pulse"}, {15'd0, done}, 16'd0);
  endtask

  initial begin
    logic [15:0] corr;
    logic        cy;
    logic [7:0]  ea, ef, f;
    logic [31:0] r;

    reset_n = 1'b0; start = 1'b0; a_in = 8'h00; f_in = 8'h00;
    corr_in = 16'h0000; corr_c_in = 1'b0;
    tick(); tick();
    check("rst.outs", {busy, done, 6'd0, a_out}, 16'h0000);
    check("rst.f_dec", {f_out, dec_a}, 16'h0000);
    check("rst.dec_f", {8'h00, dec_f}, 16'h0000);
    reset_n = 1'b1;
    tick();

    run_op("t1", 8'h3C, 8'h00, 16'h0006, 1'b0, 8'h42, 8'h14);
    run_op("t2", 8'h9A, 8'h00, 16'h0066, 1'b1, 8'h00, 8'h55);
    run_op("t3", 8'h0F, 8'h12, 16'h00FA, 1'b0, 8'h09, 8'h0E);

    // Reset sampled while in ADD aborts the operation
    start = 1'b1; a_in = 8'h3C; f_in = 8'h00; junk_inputs();
    tick();
    start = 1'b0; corr_in = 16'h0006; corr_c_in = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    check("rst_mid.busy", {15'd0, busy}, 16'd0);
    check("rst_mid.af", {a_out, f_out}, 16'h0000);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_mid.no_done", {15'd0, done}, 16'd0);
    end
    run_op("after_rst", 8'h9A, 8'h00, 16'h0066, 1'b1, 8'h00, 8'h55);

    // Start during DEC ignored; start held through done cycle is accepted
    start = 1'b1; a_in = 8'h3C; f_in = 8'h00; junk_inputs();
    tick();
    a_in = 8'h55; f_in = 8'h12; corr_in = 16'h0006; corr_c_in = 1'b0;
    tick();
    check("busy_start.dec", {dec_a, dec_f}, 16'h3C00);
    start = 1'b0; junk_inputs();
    tick();
    start = 1'b1; a_in = 8'h9A; f_in = 8'h00;
    tick();
    check("b2b.first", {a_out, f_out}, 16'h4214);
    check("b2b.done1", {15'd0, done}, 16'd1);
    tick();
    check("b2b.accept", {14'd0, busy, done}, 16'b10);
    check("b2b.dec", {dec_a, dec_f}, 16'h9A00);
    start = 1'b0; corr_in = 16'h0066; corr_c_in = 1'b1;
    tick();
    junk_inputs();
    tick();
    check("b2b.not_yet", {15'd0, done}, 16'd0);
    tick();
    check("b2b.done2", {15'd0, done}, 16'd1);
    check("b2b.second", {a_out, f_out}, 16'h0055);
    tick();

    // Sweep A x {N,H,C} with random don't-care flag bits
    for (int a = 0; a < 256; a++) begin
      for (int k = 0; k < 8; k++) begin
        r = $urandom;
        f = r[7:0] & 8'hEC;
        f[1] = k[2]; f[4] = k[1]; f[0] = k[0];
        dec_model(8'(a), f, corr, cy);
        daa_ref(8'(a), f, ea, ef);
        run_op("sweep", 8'(a), f, corr, cy, ea, ef);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
